// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM states, access sizing.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } lsu_state_t;

  // Access size in bytes; encodings with funct3[1:0]==3 are illegal and faulted elsewhere.
  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Bundle of request, response and data-memory signals for the load/store unit.
interface lsu_if #(
  parameter int unsigned ADDRESS_WIDTH = 17
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [2:0]               req_funct3;
  logic [31:0]              req_addr;
  logic [31:0]              req_wdata;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [31:0]              resp_rdata;
  logic                     resp_fault;
  logic                     mem_we0;
  logic                     mem_we1;
  logic                     mem_we2;
  logic                     mem_we3;
  logic [ADDRESS_WIDTH-1:0] mem_a;
  logic [31:0]              mem_wd;
  logic [31:0]              mem_rd;

  // Environment side: execute stage issuing requests plus the data memory answering reads.
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  mem_we0, mem_we1, mem_we2, mem_we3, mem_a, mem_wd
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output mem_we0, mem_we1, mem_we2, mem_we3, mem_a, mem_wd
  );
endinterface

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of the raw memory word according to the load funct3.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] word,
  output logic [31:0] result
);

  always_comb begin
    result = word;
    case (funct3)
      F3_LB:   result = {{24{word[7]}}, word[7:0]};
      F3_LH:   result = {{16{word[15]}}, word[15:0]};
      F3_LBU:  result = {24'h000000, word[7:0]};
      F3_LHU:  result = {16'h0000, word[15:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Core-side initiator for the byte-lane data memory: one request in flight, faults checked on
// accept, a single ACCESS cycle, then a registered response held until consumed.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH    = 17,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter bit          ALLOW_MISALIGNED = 1'b0
) (
  input logic  CLK,
  input logic  RST_N,
  lsu_if.slave bus
);

  localparam int unsigned EndW = ADDRESS_WIDTH + 1;

  lsu_state_t               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic [DATA_WIDTH-1:0]    ext_data;
  logic [2:0]               funct3_q;
  logic                     we_q;
  logic                     fault_q;

  logic            accept;
  logic            fault;
  logic            illegal;
  logic            misaligned;
  logic            out_of_range;
  logic [2:0]      size;
  logic [EndW-1:0] end_addr;
  logic [3:0]      lanes;
  logic            store_en;

  assign bus.req_ready = (state_q == IDLE) || ((state_q == RESP) && bus.resp_ready);
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    size       = size_bytes(bus.req_funct3);
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (bus.req_we) begin
      illegal = bus.req_funct3 > F3_SW;
    end else begin
      illegal = (bus.req_funct3 == 3'd3) || (bus.req_funct3[2:1] == 2'b11);
    end
    if (!ALLOW_MISALIGNED) begin
      misaligned = ((size == 3'd2) && bus.req_addr[0]) ||
                   ((size == 3'd4) && (bus.req_addr[1:0] != 2'b00));
    end
    // One extra bit catches accesses that would run past the top of memory.
    end_addr     = {1'b0, bus.req_addr[ADDRESS_WIDTH-1:0]} + EndW'(size - 3'd1);
    out_of_range = (bus.req_addr[31:ADDRESS_WIDTH] != '0) || end_addr[ADDRESS_WIDTH];
    fault        = illegal || misaligned || out_of_range;
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = fault ? RESP : ACCESS;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        ACCESS:  state_d = RESP;
        RESP:    state_d = bus.resp_ready ? IDLE : RESP;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= 3'd0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= bus.req_addr[ADDRESS_WIDTH-1:0];
        wdata_q  <= bus.req_wdata;
        funct3_q <= bus.req_funct3;
        we_q     <= bus.req_we;
        rdata_q  <= '0;
        fault_q  <= fault;
      end else if (state_q == ACCESS) begin
        rdata_q <= we_q ? '0 : ext_data;
        fault_q <= 1'b0;
      end
    end
  end

  lsu_load_ext u_load_ext (
    .funct3 (funct3_q),
    .word   (bus.mem_rd),
    .result (ext_data)
  );

  always_comb begin
    lanes = 4'b0000;
    case (funct3_q[1:0])
      2'd0:    lanes = 4'b0001;
      2'd1:    lanes = 4'b0011;
      2'd2:    lanes = 4'b1111;
      default: lanes = 4'b0000;
    endcase
  end

  // RST_N gates the enables so a reset edge landing on ACCESS never commits a write.
  assign store_en    = (state_q == ACCESS) && we_q && RST_N;
  assign bus.mem_we0 = store_en && lanes[0];
  assign bus.mem_we1 = store_en && lanes[1];
  assign bus.mem_we2 = store_en && lanes[2];
  assign bus.mem_we3 = store_en && lanes[3];
  assign bus.mem_a   = addr_q;
  assign bus.mem_wd  = wdata_q;

  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_fault = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: aligned-only and misaligned-capable instances run in lockstep
// against a transaction-level reference model, plus directed literal expectations.
module tb_load_store_unit;

  localparam int unsigned Aw   = 17;
  localparam int          MemN = 131072;

  logic CLK;
  logic RST_N;

  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_f3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_ready;
  logic        mem_clear;
  logic        chk_en;

  int n_pass;
  int n_total;

  logic [7:0] bmem    [2][MemN];
  logic [7:0] ref_mem [2][MemN];

  int          m_phase [2];
  logic [31:0] m_rdata [2];
  logic        m_fault [2];
  logic        m_we    [2];
  logic [16:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [2:0]  m_f3    [2];

  lsu_if #(.ADDRESS_WIDTH(Aw)) ifa ();
  lsu_if #(.ADDRESS_WIDTH(Aw)) ifb ();

  load_store_unit #(.ADDRESS_WIDTH(Aw), .DATA_WIDTH(32), .ALLOW_MISALIGNED(1'b0)) dut_a (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (ifa)
  );

  load_store_unit #(.ADDRESS_WIDTH(Aw), .DATA_WIDTH(32), .ALLOW_MISALIGNED(1'b1)) dut_b (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (ifb)
  );

  assign ifa.req_valid  = req_valid;
  assign ifa.req_we     = req_we;
  assign ifa.req_funct3 = req_f3;
  assign ifa.req_addr   = req_addr;
  assign ifa.req_wdata  = req_wdata;
  assign ifa.resp_ready = resp_ready;
  assign ifb.req_valid  = req_valid;
  assign ifb.req_we     = req_we;
  assign ifb.req_funct3 = req_f3;
  assign ifb.req_addr   = req_addr;
  assign ifb.req_wdata  = req_wdata;
  assign ifb.resp_ready = resp_ready;

  always_comb begin
    ifa.mem_rd = {bmem[0][ifa.mem_a + 17'd3], bmem[0][ifa.mem_a + 17'd2],
                  bmem[0][ifa.mem_a + 17'd1], bmem[0][ifa.mem_a]};
    ifb.mem_rd = {bmem[1][ifb.mem_a + 17'd3], bmem[1][ifb.mem_a + 17'd2],
                  bmem[1][ifb.mem_a + 17'd1], bmem[1][ifb.mem_a]};
  end

  // Byte-lane data memory seen by each DUT.
  always @(posedge CLK) begin
    if (mem_clear) begin
      for (int i = 0; i < MemN; i++) begin
        bmem[0][i] <= 8'h00;
        bmem[1][i] <= 8'h00;
      end
    end else begin
      if (ifa.mem_we0) bmem[0][ifa.mem_a]         <= ifa.mem_wd[7:0];
      if (ifa.mem_we1) bmem[0][ifa.mem_a + 17'd1] <= ifa.mem_wd[15:8];
      if (ifa.mem_we2) bmem[0][ifa.mem_a + 17'd2] <= ifa.mem_wd[23:16];
      if (ifa.mem_we3) bmem[0][ifa.mem_a + 17'd3] <= ifa.mem_wd[31:24];
      if (ifb.mem_we0) bmem[1][ifb.mem_a]         <= ifb.mem_wd[7:0];
      if (ifb.mem_we1) bmem[1][ifb.mem_a + 17'd1] <= ifb.mem_wd[15:8];
      if (ifb.mem_we2) bmem[1][ifb.mem_a + 17'd2] <= ifb.mem_wd[23:16];
      if (ifb.mem_we3) bmem[1][ifb.mem_a + 17'd3] <= ifb.mem_wd[31:24];
    end
  end

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic int f3_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  // Reference model: transaction level, advanced on each rising edge.
  task automatic model_loop();
    forever begin
      @(posedge CLK);
      if (mem_clear) begin
        for (int i = 0; i < MemN; i++) begin
          ref_mem[0][i] = 8'h00;
          ref_mem[1][i] = 8'h00;
        end
      end
      for (int d = 0; d < 2; d++) begin
        if (!RST_N) begin
          m_phase[d] = 0;
        end else begin
          bit acc;
          acc = req_valid && (m_phase[d] == 0 || (m_phase[d] == 2 && resp_ready));
          if (m_phase[d] == 1) begin
            int sz;
            longint v;
            sz = f3_size(m_f3[d]);
            v  = 0;
            for (int k = 0; k < sz; k++) begin
              if (m_we[d]) ref_mem[d][int'(m_addr[d]) + k] = m_wdata[d][8*k +: 8];
              else v = v + (longint'(ref_mem[d][int'(m_addr[d]) + k]) << (8 * k));
            end
            if (!m_f3[d][2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
              v = v - (longint'(1) << (8 * sz));
            m_rdata[d] = m_we[d] ? 32'h0 : v[31:0];
            m_fault[d] = 1'b0;
            m_phase[d] = 2;
          end else if (m_phase[d] == 2 && resp_ready) begin
            m_phase[d] = 0;
          end
          if (acc) begin
            bit legal, mis, oor;
            int sz;
            sz    = f3_size(req_f3);
            legal = req_we ? (req_f3 <= 3'd2) : (req_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            mis   = (d == 0) && ((req_addr % sz) != 0);
            oor   = (longint'(req_addr) + sz - 1) >= MemN;
            if (!legal || mis || oor) begin
              m_phase[d] = 2;
              m_rdata[d] = 32'h0;
              m_fault[d] = 1'b1;
            end else begin
              m_phase[d] = 1;
              m_we[d]    = req_we;
              m_f3[d]    = req_f3;
              m_addr[d]  = req_addr[16:0];
              m_wdata[d] = req_wdata;
            end
          end
        end
      end
    end
  endtask

  // Every falling edge: DUT outputs against the model.
  task automatic compare_loop();
    forever begin
      @(negedge CLK);
      if (chk_en) begin
        for (int d = 0; d < 2; d++) begin
          logic rdy, vld, flt;
          logic [31:0] rd, wd;
          logic [16:0] a;
          logic [3:0] we, exp_we;
          if (d == 0) begin
            rdy = ifa.req_ready; vld = ifa.resp_valid; flt = ifa.resp_fault; rd = ifa.resp_rdata;
            wd = ifa.mem_wd; a = ifa.mem_a;
            we = {ifa.mem_we3, ifa.mem_we2, ifa.mem_we1, ifa.mem_we0};
          end else begin
            rdy = ifb.req_ready; vld = ifb.resp_valid; flt = ifb.resp_fault; rd = ifb.resp_rdata;
            wd = ifb.mem_wd; a = ifb.mem_a;
            we = {ifb.mem_we3, ifb.mem_we2, ifb.mem_we1, ifb.mem_we0};
          end
          exp_we = (m_phase[d] == 1 && RST_N && m_we[d]) ? 4'((1 << f3_size(m_f3[d])) - 1) : 4'h0;
          chk($sformatf("req_ready[%0d]", d), 32'(rdy),
              32'(m_phase[d] == 0 || (m_phase[d] == 2 && resp_ready)));
          chk($sformatf("resp_valid[%0d]", d), 32'(vld), 32'(m_phase[d] == 2));
          chk($sformatf("mem_we[%0d]", d), 32'(we), 32'(exp_we));
          if (m_phase[d] == 2) begin
            chk($sformatf("resp_rdata[%0d]", d), rd, m_rdata[d]);
            chk($sformatf("resp_fault[%0d]", d), 32'(flt), 32'(m_fault[d]));
          end
          if (m_phase[d] == 1) begin
            chk($sformatf("mem_a[%0d]", d), 32'(a), 32'(m_addr[d]));
            if (m_we[d]) chk($sformatf("mem_wd[%0d]", d), wd, m_wdata[d]);
          end
        end
      end
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(posedge CLK);
    #1 req_valid = 1'b0;
  endtask

  task automatic collect(output logic [31:0] rd0, output logic f0, output int l0,
                         output logic [31:0] rd1, output logic f1, output int l1);
    bit g0, g1;
    g0 = 0; g1 = 0; l0 = -1; l1 = -1; rd0 = 'x; rd1 = 'x; f0 = 'x; f1 = 'x;
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      if (!g0 && ifa.resp_valid) begin g0 = 1; l0 = c; rd0 = ifa.resp_rdata; f0 = ifa.resp_fault; end
      if (!g1 && ifb.resp_valid) begin g1 = 1; l1 = c; rd1 = ifb.resp_rdata; f1 = ifb.resp_fault; end
    end
    if (!g0) chk("resp_timeout[0]", 32'd0, 32'd1);
    if (!g1) chk("resp_timeout[1]", 32'd0, 32'd1);
    @(posedge CLK);
    #1;
  endtask

  task automatic xact(input string name, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd0, input logic exp_f0, input int exp_l0,
                      input logic [31:0] exp_rd1, input logic exp_f1, input int exp_l1);
    logic [31:0] rd0, rd1;
    logic f0, f1;
    int l0, l1;
    issue(we, f3, addr, wd);
    collect(rd0, f0, l0, rd1, f1, l1);
    chk({name, " rdata[0]"}, rd0, exp_rd0);
    chk({name, " fault[0]"}, 32'(f0), 32'(exp_f0));
    chk({name, " latency[0]"}, 32'(l0), 32'(exp_l0));
    chk({name, " rdata[1]"}, rd1, exp_rd1);
    chk({name, " fault[1]"}, 32'(f1), 32'(exp_f1));
    chk({name, " latency[1]"}, 32'(l1), 32'(exp_l1));
  endtask

  initial begin
    logic [31:0] rd0, rd1;
    logic f0, f1;
    int l0, l1;
    n_pass = 0; n_total = 0; chk_en = 1'b0; mem_clear = 1'b1;
    RST_N = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_f3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
    fork
      model_loop();
      compare_loop();
    join_none
    repeat (2) @(posedge CLK);
    #1 mem_clear = 1'b0;
    chk("reset req_ready", 32'({ifa.req_ready, ifb.req_ready}), 32'h3);
    chk("reset resp_valid", 32'({ifa.resp_valid, ifb.resp_valid}), 32'h0);
    chk("reset resp_fault", 32'({ifa.resp_fault, ifb.resp_fault}), 32'h0);
    chk("reset resp_rdata", ifa.resp_rdata | ifb.resp_rdata, 32'h0);
    chk("reset mem_a", 32'(ifa.mem_a | ifb.mem_a), 32'h0);
    chk("reset mem_wd", ifa.mem_wd | ifb.mem_wd, 32'h0);
    chk("reset mem_we", 32'({ifa.mem_we3, ifa.mem_we2, ifa.mem_we1, ifa.mem_we0,
                             ifb.mem_we3, ifb.mem_we2, ifb.mem_we1, ifb.mem_we0}), 32'h0);
    RST_N = 1'b1;
    chk_en = 1'b1;

    xact("SW", 1'b1, 3'd2, 32'h10000, 32'hDEADBEEF, 32'h0, 1'b0, 2, 32'h0, 1'b0, 2);
    chk("SW mem byte3", 32'(bmem[0][17'h10003]), 32'hDE);
    xact("LW", 1'b0, 3'd2, 32'h10000, 32'h0, 32'hDEADBEEF, 1'b0, 2, 32'hDEADBEEF, 1'b0, 2);
    xact("SB", 1'b1, 3'd0, 32'h10003, 32'h000000A5, 32'h0, 1'b0, 2, 32'h0, 1'b0, 2);
    xact("LB", 1'b0, 3'd0, 32'h10003, 32'h0, 32'hFFFFFFA5, 1'b0, 2, 32'hFFFFFFA5, 1'b0, 2);
    xact("LBU", 1'b0, 3'd4, 32'h10003, 32'h0, 32'h000000A5, 1'b0, 2, 32'h000000A5, 1'b0, 2);
    xact("SH", 1'b1, 3'd1, 32'h10002, 32'h00008001, 32'h0, 1'b0, 2, 32'h0, 1'b0, 2);
    xact("LH", 1'b0, 3'd1, 32'h10002, 32'h0, 32'hFFFF8001, 1'b0, 2, 32'hFFFF8001, 1'b0, 2);
    xact("LHU", 1'b0, 3'd5, 32'h10002, 32'h0, 32'h00008001, 1'b0, 2, 32'h00008001, 1'b0, 2);
    xact("LW mis", 1'b0, 3'd2, 32'h10001, 32'h0, 32'h0, 1'b1, 1, 32'h008001BE, 1'b0, 2);
    xact("LW top", 1'b0, 3'd2, 32'h1FFFE, 32'h0, 32'h0, 1'b1, 1, 32'h0, 1'b1, 1);
    xact("LW high", 1'b0, 3'd2, 32'h00020000, 32'h0, 32'h0, 1'b1, 1, 32'h0, 1'b1, 1);
    xact("S f3=3", 1'b1, 3'd3, 32'h10000, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 32'h0, 1'b1, 1);
    chk("fault store mem[0]", 32'(bmem[0][17'h10000]), 32'hEF);
    chk("fault store mem[1]", 32'(bmem[1][17'h10000]), 32'hEF);

    // Stalled consumer, then a new request accepted on the same edge the response drains.
    resp_ready = 1'b0;
    issue(1'b0, 3'd2, 32'h10000, 32'h0);
    repeat (6) @(posedge CLK);
    #1;
    chk("stall req_ready", 32'({ifa.req_ready, ifb.req_ready}), 32'h0);
    chk("stall resp_valid", 32'({ifa.resp_valid, ifb.resp_valid}), 32'h3);
    chk("stall rdata[0]", ifa.resp_rdata, 32'h8001BEEF);
    chk("stall rdata[1]", ifb.resp_rdata, 32'h8001BEEF);
    resp_ready = 1'b1;
    issue(1'b0, 3'd0, 32'h10000, 32'h0);
    collect(rd0, f0, l0, rd1, f1, l1);
    chk("b2b LB rdata[0]", rd0, 32'hFFFFFFEF);
    chk("b2b LB latency[0]", 32'(l0), 32'd2);
    chk("b2b LB rdata[1]", rd1, 32'hFFFFFFEF);

    // Reset landing on a store's ACCESS cycle.
    issue(1'b1, 3'd2, 32'h10010, 32'h12345678);
    RST_N = 1'b0;
    @(posedge CLK);
    #1 RST_N = 1'b1;
    chk("rst resp_valid", 32'({ifa.resp_valid, ifb.resp_valid}), 32'h0);
    chk("rst req_ready", 32'({ifa.req_ready, ifb.req_ready}), 32'h3);
    chk("rst mem[0]", 32'(bmem[0][17'h10010]), 32'h0);
    chk("rst mem[1]", 32'(bmem[1][17'h10010]), 32'h0);
    xact("LW after rst", 1'b0, 3'd2, 32'h10010, 32'h0, 32'h0, 1'b0, 2, 32'h0, 1'b0, 2);

    repeat (2) @(posedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
